// File: rtl/ksa32_sum_stage_if.sv
// Handshake and data bundle for the Kogge-Stone sum stage.
// The upstream (prefix stage) and downstream sides share one interface:
// the master modport is the environment, the slave modport is the stage.
interface ksa32_sum_stage_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] G_i;
    logic [DATA_W-1:0] P_i;
    logic [DATA_W-1:0] H_i;
    logic              cin_i;
    logic [TAG_W-1:0]  tag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] sum_o;
    logic              cout_o;
    logic              ovf_o;
    logic              zero_o;
    logic [TAG_W-1:0]  tag_o;

    modport slave (
        input  in_valid_i, G_i, P_i, H_i, cin_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, zero_o, tag_o
    );

    modport master (
        output in_valid_i, G_i, P_i, H_i, cin_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, zero_o, tag_o
    );
endinterface

// File: rtl/ksa32_sum_stage.sv
// Final registered stage of the 32-bit Kogge-Stone adder.
// Turns group generate/propagate plus half-sum bits into sum, carry-out,
// signed overflow and zero flag, presented through a valid/ready register.
// Build option: define KSA_SUM_SKID_EN for a 2-entry skid buffer whose
// in_ready_o comes from a flop; otherwise a single output register is used.
module ksa32_sum_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ksa32_sum_stage_if.slave      bus
);
    // Packed result: {sum, cout, ovf, zero, tag}
    localparam int RES_W = DATA_W + 3 + TAG_W;

    generate
        if (DATA_W != 32) begin : g_bad_width
            $error("ksa32_sum_stage: only DATA_W = 32 is supported");
        end
    endgenerate

    // Carry into each bit position; carry[DATA_W] is the carry-out.
    logic [DATA_W:0]   carry;
    logic [DATA_W-1:0] sum_c;
    logic [RES_W-1:0]  result_c;
    logic              in_ready;
    logic              in_xfer;
    logic              out_xfer;

    assign carry[0] = bus.cin_i;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_carry
            assign carry[gi+1] = bus.G_i[gi] | (bus.P_i[gi] & bus.cin_i);
        end
    endgenerate

    // Result formation from carries and half-sum bits.
    always_comb begin
        sum_c    = bus.H_i ^ carry[DATA_W-1:0];
        result_c = {sum_c, carry[DATA_W], carry[DATA_W] ^ carry[DATA_W-1],
                    ~|sum_c, bus.tag_i};
    end

    logic             main_valid_q, main_valid_d;
    logic [RES_W-1:0] main_res_q,   main_res_d;

    assign in_xfer  = bus.in_valid_i & in_ready;
    assign out_xfer = main_valid_q & bus.out_ready_i;

`ifdef KSA_SUM_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [RES_W-1:0] skid_res_q,   skid_res_d;

    // Ready depends only on the skid occupancy flop (and reset), never on out_ready_i.
    assign in_ready = ~rst_i & ~skid_valid_q;

    // FIFO steering: main refills from skid first, then from the input.
    always_comb begin
        main_valid_d = main_valid_q;
        main_res_d   = main_res_q;
        skid_valid_d = skid_valid_q;
        skid_res_d   = skid_res_q;
        if (!main_valid_q || out_xfer) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_res_d   = skid_res_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_valid_d = 1'b1;
                main_res_d   = result_c;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_res_d   = result_c;
        end
    end

    // Skid register state; reset discards any buffered result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_valid_q <= 1'b0;
            skid_res_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_res_q   <= skid_res_d;
        end
    end
`else
    // Single register: accept when empty or when the held result leaves this cycle.
    assign in_ready = ~rst_i & (~main_valid_q | bus.out_ready_i);

    // Load on input transfer; drain to empty on an output-only transfer.
    always_comb begin
        main_valid_d = main_valid_q;
        main_res_d   = main_res_q;
        if (in_xfer) begin
            main_valid_d = 1'b1;
            main_res_d   = result_c;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    // Output register; reset clears valid and all result fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_res_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_res_q   <= main_res_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = main_valid_q;
    assign {bus.sum_o, bus.cout_o, bus.ovf_o, bus.zero_o, bus.tag_o} = main_res_q;

endmodule
